// File: rtl/program_loader.sv
// program_loader: byte-stream program loader for the 8-bit RISC core.
// Accepts a valid/ready byte stream, packs byte pairs (high byte first) into
// instructions, writes them to instruction memory from address 0 upward, then
// checks a trailing two's-complement checksum byte. The core is held in reset
// until a load completes with a good checksum.
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   load_start           pulse: begin a load (ignored while busy)
//   load_count           instruction count, sampled with load_start
//   byte_valid/data      input stream; byte_ready is the handshake back
//   imem_we/addr/wdata   registered instruction memory write port
//   core_rst             registered reset to the core (1 = held)
//   busy                 load in progress
//   load_done            one-cycle pulse on a successful load
//   err                  sticky failure flag, cleared by the next accepted load_start
`timescale 1ns/1ps
module program_loader #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned DEPTH       = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    input  logic [ADDR_WIDTH:0]    load_count,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   core_rst,
    output logic                   busy,
    output logic                   load_done,
    output logic                   err
);

    localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [2:0] {StHalt, StRxHi, StRxLo, StWrite, StRxCsum, StRun} state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [7:0]              sum_q, sum_d;
    logic [7:0]              hi_q, hi_d;
    logic                    imem_we_q, imem_we_d;
    logic [ADDR_WIDTH-1:0]   imem_addr_q, imem_addr_d;
    logic [INSTR_WIDTH-1:0]  imem_wdata_q, imem_wdata_d;
    logic                    core_rst_q, core_rst_d;
    logic                    load_done_q, load_done_d;
    logic                    err_q, err_d;
    logic [7:0]              sum_next;
    logic                    count_ok;

    assign sum_next = sum_q + byte_data;
    assign count_ok = (load_count != '0) && (load_count <= DepthW);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        count_d      = count_q;
        sum_d        = sum_q;
        hi_d         = hi_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        load_done_d  = 1'b0;
        err_d        = err_q;
        case (state_q)
            StHalt, StRun: begin
                // load_start has priority; a concurrent byte is not consumed here
                if (load_start) begin
                    if (count_ok) begin
                        err_d   = 1'b0;
                        idx_d   = '0;
                        sum_d   = '0;
                        count_d = load_count;
                        state_d = StRxHi;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StHalt;
                    end
                end
            end
            StRxHi: begin
                if (byte_valid) begin
                    hi_d    = byte_data;
                    sum_d   = sum_next;
                    state_d = StRxLo;
                end
            end
            StRxLo: begin
                // Load the write port now so it is registered during StWrite
                if (byte_valid) begin
                    sum_d        = sum_next;
                    imem_we_d    = 1'b1;
                    imem_addr_d  = idx_q;
                    imem_wdata_d = {hi_q, byte_data};
                    state_d      = StWrite;
                end
            end
            StWrite: begin
                if ({1'b0, idx_q} == (count_q - 1'b1)) begin
                    state_d = StRxCsum;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StRxHi;
                end
            end
            StRxCsum: begin
                if (byte_valid) begin
                    if (sum_next == 8'h00) begin
                        load_done_d = 1'b1;
                        state_d     = StRun;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StHalt;
                    end
                end
            end
            default: state_d = StHalt;
        endcase
        core_rst_d = (state_d != StRun);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StHalt;
            idx_q        <= '0;
            count_q      <= '0;
            sum_q        <= '0;
            hi_q         <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b1;
            load_done_q  <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
            hi_q         <= hi_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            load_done_q  <= load_done_d;
            err_q        <= err_d;
        end
    end

    assign byte_ready = (state_q == StRxHi) || (state_q == StRxLo) || (state_q == StRxCsum);
    assign busy       = (state_q != StHalt) && (state_q != StRun);
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign load_done  = load_done_q;
    assign err        = err_q;

endmodule
